// File: rtl/obstacle_sweep.sv
// Walks the active obstacle list, launches the collision unit per obstacle and chains results.
// Optional WAIT watchdog: define OBSTACLE_SWEEP_TIMEOUT_EN.
module obstacle_sweep #(
    parameter int POSITION_SIZE     = 16,
    parameter int VELOCITY_SIZE     = 16,
    parameter int ACCELERATION_SIZE = 16,
    parameter int NUM_VERTICES      = 5,
    parameter int NUM_OBSTACLES     = 8,
    parameter int MEM_LATENCY       = 2,
    parameter int TIMEOUT_CYCLES    = 255,
    localparam int OBS_AW           = $clog2(NUM_OBSTACLES),
    localparam int VCW              = $clog2(NUM_VERTICES) + 1
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              step_valid_in,
    output logic                                              step_ready_out,
    input  logic [OBS_AW:0]                                   num_obstacles_in,
    input  logic [POSITION_SIZE-1:0]                          pos_x_in, pos_y_in, dx_in, dy_in,
    input  logic [VELOCITY_SIZE-1:0]                          vel_x_in, vel_y_in,
    output logic [OBS_AW-1:0]                                 obs_addr_out,
    input  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]   obs_vertices_in,
    input  logic [VCW-1:0]                                    obs_count_in,
    output logic                                              coll_begin_out,
    output logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]   coll_obstacle_out,
    output logic [VCW-1:0]                                    coll_num_vertices_out,
    output logic [POSITION_SIZE-1:0]                          coll_pos_x_out, coll_pos_y_out,
    output logic [VELOCITY_SIZE-1:0]                          coll_vel_x_out, coll_vel_y_out,
    output logic [POSITION_SIZE-1:0]                          coll_dx_out, coll_dy_out,
    input  logic                                              coll_result_in,
    input  logic                                              coll_was_collision_in,
    input  logic [POSITION_SIZE-1:0]                          coll_x_new_in, coll_y_new_in,
    input  logic [POSITION_SIZE-1:0]                          coll_x_int_in, coll_y_int_in,
    input  logic [VELOCITY_SIZE-1:0]                          coll_vel_x_new_in, coll_vel_y_new_in,
    input  logic [ACCELERATION_SIZE-1:0]                      coll_acc_x_in, coll_acc_y_in,
    output logic                                              step_valid_out,
    output logic [POSITION_SIZE-1:0]                          x_out, y_out,
    output logic [VELOCITY_SIZE-1:0]                          vel_x_out, vel_y_out,
    output logic [ACCELERATION_SIZE-1:0]                      acc_x_out, acc_y_out,
    output logic [OBS_AW:0]                                   hit_count_out,
    output logic                                              timeout_out
);
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LAUNCH, ST_WAIT, ST_MERGE, ST_DONE} state_t;
    localparam int NW  = OBS_AW + 1;
    localparam int FCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int AS  = ACCELERATION_SIZE;

    state_t                  state_r;
    logic [NW-1:0]           n_r, idx_r, hits_r, n_sat_s, idx_next_s;
    logic [FCW-1:0]          fetch_cnt_r;
    logic [POSITION_SIZE-1:0] pos_x_r, pos_y_r, dx_r, dy_r, fin_x_r, fin_y_r;
    logic [VELOCITY_SIZE-1:0] vel_x_r, vel_y_r;
    logic [AS-1:0]           acc_x_r, acc_y_r;
    logic                    hit_any_r;

    // Two's-complement add clamped to the signed accumulator range.
    function automatic logic [AS-1:0] sat_add(input logic [AS-1:0] a, input logic [AS-1:0] b);
        logic [AS:0] sum;
        sum = {a[AS-1], a} + {b[AS-1], b};
        if (sum[AS] != sum[AS-1]) begin
            if (sum[AS]) return {1'b1, {(AS-1){1'b0}}};
            else         return {1'b0, {(AS-1){1'b1}}};
        end else begin
            return sum[AS-1:0];
        end
    endfunction

`ifdef OBSTACLE_SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt_r;
    logic          timeout_r;
    assign timeout_out = timeout_r;
`else
    assign timeout_out = 1'b0;
`endif

    // Active obstacle count clamped to the memory depth, and next list index.
    always_comb begin
        if (num_obstacles_in > NW'(NUM_OBSTACLES)) begin
            n_sat_s = NW'(NUM_OBSTACLES);
        end else begin
            n_sat_s = num_obstacles_in;
        end
        idx_next_s = idx_r + NW'(1);
    end

    // Sweep sequencer: all working state and every output register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
            n_r <= '0; idx_r <= '0; hits_r <= '0; fetch_cnt_r <= '0; hit_any_r <= 1'b0;
            pos_x_r <= '0; pos_y_r <= '0; dx_r <= '0; dy_r <= '0; fin_x_r <= '0; fin_y_r <= '0;
            vel_x_r <= '0; vel_y_r <= '0; acc_x_r <= '0; acc_y_r <= '0;
            step_ready_out <= 1'b1; obs_addr_out <= '0; coll_begin_out <= 1'b0;
            coll_obstacle_out <= '0; coll_num_vertices_out <= '0;
            coll_pos_x_out <= '0; coll_pos_y_out <= '0; coll_vel_x_out <= '0; coll_vel_y_out <= '0;
            coll_dx_out <= '0; coll_dy_out <= '0;
            step_valid_out <= 1'b0; x_out <= '0; y_out <= '0; vel_x_out <= '0; vel_y_out <= '0;
            acc_x_out <= '0; acc_y_out <= '0; hit_count_out <= '0;
`ifdef OBSTACLE_SWEEP_TIMEOUT_EN
            wait_cnt_r <= '0; timeout_r <= 1'b0;
`endif
        end else begin
            step_valid_out <= 1'b0;
            coll_begin_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Ready rises one cycle after the result pulse.
                    if (!step_ready_out) begin
                        step_ready_out <= 1'b1;
                    end else if (step_valid_in) begin
                        step_ready_out <= 1'b0;
                        pos_x_r <= pos_x_in; pos_y_r <= pos_y_in; dx_r <= dx_in; dy_r <= dy_in;
                        vel_x_r <= vel_x_in; vel_y_r <= vel_y_in;
                        acc_x_r <= '0; acc_y_r <= '0; hits_r <= '0; hit_any_r <= 1'b0;
                        idx_r <= '0; obs_addr_out <= '0; fetch_cnt_r <= '0; n_r <= n_sat_s;
`ifdef OBSTACLE_SWEEP_TIMEOUT_EN
                        timeout_r <= 1'b0;
`endif
                        state_r <= (n_sat_s == NW'(0)) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_cnt_r == FCW'(MEM_LATENCY - 1)) begin
                        fetch_cnt_r <= '0;
                        if (obs_count_in < VCW'(2)) begin
                            state_r <= ST_MERGE;
                        end else begin
                            coll_obstacle_out <= obs_vertices_in;
                            coll_num_vertices_out <= obs_count_in;
                            coll_pos_x_out <= pos_x_r; coll_pos_y_out <= pos_y_r;
                            coll_vel_x_out <= vel_x_r; coll_vel_y_out <= vel_y_r;
                            coll_dx_out <= dx_r; coll_dy_out <= dy_r;
                            coll_begin_out <= 1'b1;
                            state_r <= ST_LAUNCH;
                        end
                    end else begin
                        fetch_cnt_r <= fetch_cnt_r + FCW'(1);
                    end
                end
                ST_LAUNCH: begin
`ifdef OBSTACLE_SWEEP_TIMEOUT_EN
                    wait_cnt_r <= '0;
`endif
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Collision results are folded in here; MERGE only advances the index.
                    if (coll_result_in) begin
                        if (coll_was_collision_in) begin
                            pos_x_r <= coll_x_int_in; pos_y_r <= coll_y_int_in;
                            vel_x_r <= coll_vel_x_new_in; vel_y_r <= coll_vel_y_new_in;
                            dx_r <= coll_x_new_in - coll_x_int_in;
                            dy_r <= coll_y_new_in - coll_y_int_in;
                            fin_x_r <= coll_x_new_in; fin_y_r <= coll_y_new_in;
                            hit_any_r <= 1'b1; hits_r <= hits_r + NW'(1);
                            acc_x_r <= sat_add(acc_x_r, coll_acc_x_in);
                            acc_y_r <= sat_add(acc_y_r, coll_acc_y_in);
                        end
                        state_r <= ST_MERGE;
                    end
`ifdef OBSTACLE_SWEEP_TIMEOUT_EN
                    else if (wait_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_r <= 1'b1;
                        state_r <= ST_MERGE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
`endif
                end
                ST_MERGE: begin
                    if (idx_next_s == n_r) begin
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_next_s;
                        obs_addr_out <= idx_next_s[OBS_AW-1:0];
                        state_r <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    step_valid_out <= 1'b1;
                    x_out <= hit_any_r ? fin_x_r : pos_x_r + dx_r;
                    y_out <= hit_any_r ? fin_y_r : pos_y_r + dy_r;
                    vel_x_out <= vel_x_r; vel_y_out <= vel_y_r;
                    acc_x_out <= acc_x_r; acc_y_out <= acc_y_r;
                    hit_count_out <= hits_r;
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
